// File: rtl/pixel_test_pkg.sv
// Shared definitions for the single-pixel test system: sample widths, packet
// layout, FSM encodings and the packet builder used by the UART transmitter.
package pixel_test_pkg;

   localparam int unsigned DATA_W  = 12;
   localparam int unsigned CH_W    = 3;
   localparam int unsigned SEQ_W   = 4;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned COUNT_W = 8;
   localparam int unsigned PKT_LEN = 5;
   localparam int unsigned IDX_W   = 3;

   localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

   typedef enum logic [1:0] {
      U_IDLE,
      U_START_BIT,
      U_DATA_BITS,
      U_STOP_BIT
   } uart_state_e;

   typedef enum logic [1:0] {
      P_IDLE,
      P_SEND,
      P_NEXT_BYTE
   } pkt_state_e;

   typedef logic [PKT_LEN-1:0][BYTE_W-1:0] packet_t;

   // Header, seq/channel, data high nibble, data low byte, XOR checksum.
   function automatic packet_t build_packet(input logic [BYTE_W-1:0] header,
                                            input logic [SEQ_W-1:0]  seq,
                                            input logic [CH_W-1:0]   channel,
                                            input logic [DATA_W-1:0] data);
      packet_t p;
      p[0] = header;
      p[1] = {seq, 1'b0, channel};
      p[2] = {4'b0000, data[DATA_W-1:8]};
      p[3] = data[7:0];
      p[4] = p[1] ^ p[2] ^ p[3];
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser for a single byte: start strobe in, registered tx line and
// a one-cycle done pulse coinciding with the last cycle of the stop bit.
module uart_tx_byte
   import pixel_test_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 434
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              start_i,
   input  logic [BYTE_W-1:0] data_i,
   output logic              tx_o,
   output logic              done_o
);

   localparam int unsigned       CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(BAUD_DIV - 2);

   uart_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_q;
   logic [BYTE_W-1:0] shift_q;
   logic              tx_q;
   logic              done_q;
   logic              cnt_last_c;

   assign cnt_last_c = (cnt_q == CNT_LAST);

   // Baud counter restarts on every bit so byte timing never drifts.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= U_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            U_IDLE: begin
               if (start_i) begin
                  shift_q <= data_i;
                  tx_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= U_START_BIT;
               end
            end
            U_START_BIT: begin
               if (cnt_last_c) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= U_DATA_BITS;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            U_DATA_BITS: begin
               if (cnt_last_c) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= U_STOP_BIT;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            U_STOP_BIT: begin
               done_q <= (cnt_q == CNT_DONE);
               if (cnt_last_c) begin
                  cnt_q   <= '0;
                  state_q <= U_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= U_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx_o   = tx_q;
   assign done_o = done_q;

endmodule

// File: rtl/pixel_sample_uart_tx.sv
// Packs one ADC sample per frame into a 5-byte packet and sends it as UART
// 8N1; busy/sample_ready gate the controller's transmission phase.
module pixel_sample_uart_tx
   import pixel_test_pkg::*;
#(
   parameter int unsigned       CLK_HZ   = 50000000,
   parameter int unsigned       BAUD     = 115200,
   parameter int unsigned       BAUD_DIV = CLK_HZ / BAUD,
   parameter logic [BYTE_W-1:0] HEADER   = HEADER_DEFAULT
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic [DATA_W-1:0]  sample_data,
   input  logic [CH_W-1:0]    sample_channel,
   input  logic               sample_valid,
   output logic               sample_ready,
   output logic               overrun,
   output logic               tx,
   output logic               busy,
   output logic [COUNT_W-1:0] pkt_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

   pkt_state_e         state_q;
   packet_t            pkt_q;
   logic [IDX_W-1:0]   idx_q;
   logic [SEQ_W-1:0]   seq_q;
   logic [COUNT_W-1:0] pkt_count_q;
   logic               ready_q;
   logic               busy_q;
   logic               overrun_q;

   logic               accept_c;
   logic               start_c;
   logic [BYTE_W-1:0]  byte_c;
   logic [IDX_W-1:0]   nxt_idx_c;
   logic               byte_done;

   assign accept_c  = sample_valid & ready_q;
   assign nxt_idx_c = idx_q + IDX_W'(1);

   // Byte launch: the header straight from acceptance, later bytes from NEXT_BYTE.
   always_comb begin
      start_c = 1'b0;
      byte_c  = HEADER;
      case (state_q)
         P_IDLE:      start_c = accept_c;
         P_NEXT_BYTE: begin
            if (idx_q < LAST_IDX) begin
               start_c = 1'b1;
               byte_c  = pkt_q[nxt_idx_c];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q     <= P_IDLE;
         pkt_q       <= '0;
         idx_q       <= '0;
         seq_q       <= '0;
         pkt_count_q <= '0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         overrun_q <= sample_valid & ~ready_q;
         case (state_q)
            P_IDLE: begin
               if (accept_c) begin
                  pkt_q   <= build_packet(HEADER, seq_q, sample_channel, sample_data);
                  idx_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= P_SEND;
               end
            end
            P_SEND: begin
               if (byte_done) state_q <= P_NEXT_BYTE;
            end
            P_NEXT_BYTE: begin
               if (idx_q < LAST_IDX) begin
                  idx_q   <= nxt_idx_c;
                  state_q <= P_SEND;
               end else begin
                  seq_q       <= seq_q + SEQ_W'(1);
                  pkt_count_q <= pkt_count_q + COUNT_W'(1);
                  ready_q     <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= P_IDLE;
               end
            end
            default: begin
               state_q <= P_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_byte (
      .clk_in  (clk_in),
      .reset   (reset),
      .start_i (start_c),
      .data_i  (byte_c),
      .tx_o    (tx),
      .done_o  (byte_done)
   );

   assign sample_ready = ready_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;
   assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_pixel_sample_uart_tx.sv
// Directed bench for pixel_sample_uart_tx at BAUD_DIV=10: table of packets
// plus hand sequences for sequence wrap, overrun and mid-packet reset.
module tb_pixel_sample_uart_tx;

   localparam int DIV      = 10;
   localparam int BYTE_CYC = 10 * DIV + 1;
   localparam int BUSY_CYC = 50 * DIV + 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] sample_data;
   logic [2:0]  sample_channel;
   logic        sample_valid;
   logic        sample_ready;
   logic        overrun;
   logic        tx;
   logic        busy;
   logic [7:0]  pkt_count;

   always #5 clk = ~clk;

   pixel_sample_uart_tx #(
      .CLK_HZ (1000),
      .BAUD   (100),
      .HEADER (8'hA5)
   ) dut (
      .clk_in         (clk),
      .reset          (rst),
      .sample_data    (sample_data),
      .sample_channel (sample_channel),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .overrun        (overrun),
      .tx             (tx),
      .busy           (busy),
      .pkt_count      (pkt_count)
   );

   typedef struct {
      bit              do_reset;
      logic [11:0]     data;
      logic [2:0]      ch;
      logic [4:0][7:0] bytes;
      int              cnt;
   } vec_t;

   vec_t vecs [5];
   logic tr_tx   [0:1023];
   logic tr_busy [0:1023];
   logic tr_ovr  [0:1023];
   logic tr_rdy  [0:1023];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   function automatic logic exp_tx(input logic [4:0][7:0] b, input int c);
      int off, k, r;
      if (c < 1 || c > BUSY_CYC) return 1'b1;
      off = c - 1;
      k   = off / BYTE_CYC;
      r   = off % BYTE_CYC;
      if (r < DIV) return 1'b0;
      if (r < 9 * DIV) return b[k][(r - DIV) / DIV];
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Wait for ready, present one sample, then record ncyc cycles after acceptance.
   task automatic send_capture(input logic [11:0] d, input logic [2:0] ch,
                               input int pulse, input int ncyc);
      int waited = 0;
      @(negedge clk);
      while (!sample_ready && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_wait", int'(sample_ready), 1);
      sample_data    = d;
      sample_channel = ch;
      sample_valid   = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= ncyc; c++) begin
         sample_valid = (c == pulse);
         if (c == pulse) sample_data = ~d;
         @(negedge clk);
         tr_tx[c]   = tx;
         tr_busy[c] = busy;
         tr_ovr[c]  = overrun;
         tr_rdy[c]  = sample_ready;
         @(posedge clk);
         #1;
      end
      sample_valid = 1'b0;
   endtask

   task automatic check_packet(input string nm, input logic [4:0][7:0] exp,
                               input int exp_cnt, input int ncyc, input int exp_ovr);
      int errs = 0, bcnt = 0, ocnt = 0, run = 0;
      logic [7:0] got;
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 8; j++)
            got[j] = tr_tx[1 + k * BYTE_CYC + DIV + DIV / 2 + j * DIV];
         chk($sformatf("%s_b%0d", nm, k), int'(got), int'(exp[k]));
      end
      for (int c = 1; c <= ncyc; c++) begin
         if (tr_tx[c] !== exp_tx(exp, c)) errs++;
         if (tr_busy[c] === 1'b1) bcnt++;
         if (tr_ovr[c] === 1'b1) ocnt++;
      end
      while (run < 50 && tr_tx[run + 1] === 1'b0) run++;
      chk({nm, "_wave_errs"}, errs, 0);
      chk({nm, "_busy_cycles"}, bcnt, BUSY_CYC);
      chk({nm, "_busy_first"}, int'(tr_busy[1]), 1);
      chk({nm, "_ready_back"}, int'(tr_rdy[BUSY_CYC + 1]), 1);
      chk({nm, "_start_width"}, run, DIV);
      chk({nm, "_overruns"}, ocnt, exp_ovr);
      chk({nm, "_pkt_count"}, int'(pkt_count), exp_cnt);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0][7:0] e;
      int first;

      vecs[0] = '{do_reset: 1'b0, data: 12'hABC, ch: 3'd3, bytes: {8'hB5, 8'hBC, 8'h0A, 8'h03, 8'hA5}, cnt: 1};
      vecs[1] = '{do_reset: 1'b1, data: 12'h000, ch: 3'd0, bytes: {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, cnt: 1};
      vecs[2] = '{do_reset: 1'b1, data: 12'hFFF, ch: 3'd7, bytes: {8'hF7, 8'hFF, 8'h0F, 8'h07, 8'hA5}, cnt: 1};
      vecs[3] = '{do_reset: 1'b0, data: 12'h5A3, ch: 3'd5, bytes: {8'hB3, 8'hA3, 8'h05, 8'h15, 8'hA5}, cnt: 2};
      vecs[4] = '{do_reset: 1'b0, data: 12'h7E1, ch: 3'd2, bytes: {8'hC4, 8'hE1, 8'h07, 8'h22, 8'hA5}, cnt: 3};

      rst            = 1'b1;
      sample_valid   = 1'b0;
      sample_data    = '0;
      sample_channel = '0;
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_ready", int'(sample_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_pkt_count", int'(pkt_count), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].do_reset) do_reset();
         send_capture(vecs[v].data, vecs[v].ch, 0, BUSY_CYC + 1);
         check_packet($sformatf("vec%0d", v), vecs[v].bytes, vecs[v].cnt, BUSY_CYC + 1, 0);
      end

      // Sequence number wraps 15 -> 0 while pkt_count keeps counting.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         e[0] = 8'hA5;
         e[1] = {4'(i), 1'b0, 3'd1};
         e[2] = 8'h01;
         e[3] = 8'h23;
         e[4] = e[1] ^ 8'h22;
         send_capture(12'h123, 3'd1, 0, BUSY_CYC + 1);
         check_packet($sformatf("wrap%0d", i), e, i + 1, BUSY_CYC + 1, 0);
      end
      chk("wrap_final_count", int'(pkt_count), 17);

      // Overrun mid-packet: dropped sample leaves the packet untouched.
      do_reset();
      send_capture(12'hABC, 3'd3, 20, 520);
      check_packet("ovr20", vecs[0].bytes, 1, 520, 1);
      first = 0;
      for (int c = 520; c >= 1; c--) if (tr_ovr[c] === 1'b1) first = c;
      chk("ovr20_position", first, 21);

      // Valid during the final NEXT_BYTE cycle is refused.
      send_capture(12'h5A3, 3'd5, BUSY_CYC, 520);
      check_packet("ovr_last", vecs[3].bytes, 2, 520, 1);
      first = 0;
      for (int c = 520; c >= 1; c--) if (tr_ovr[c] === 1'b1) first = c;
      chk("ovr_last_position", first, BUSY_CYC + 1);
      repeat (30) @(negedge clk);
      chk("ovr_last_no_extra_busy", int'(busy), 0);
      chk("ovr_last_no_extra_count", int'(pkt_count), 2);

      // Reset in the middle of byte 2's data bits.
      @(negedge clk);
      chk("midrst_ready_before", int'(sample_ready), 1);
      sample_data    = 12'h321;
      sample_channel = 3'd4;
      sample_valid   = 1'b1;
      @(posedge clk);
      #1 sample_valid = 1'b0;
      repeat (249) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_tx", int'(tx), 1);
      chk("midrst_ready", int'(sample_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_pkt_count", int'(pkt_count), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      send_capture(12'hABC, 3'd3, 0, BUSY_CYC + 1);
      check_packet("after_rst", vecs[0].bytes, 1, BUSY_CYC + 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pixel_sample_uart_tx.md
Name: pixel_sample_uart_tx

Overview:
- Sits directly downstream of the ADC128S022 driver in the single-pixel test system.
- Takes one 12-bit pixel/ADC sample per frame and wraps it in a 5-byte packet: header, sequence/channel, data high, data low, XOR checksum.
- Serialises the packet as UART 8N1 to the host PC.
- Provides the work for the controller's TRANSMISSION phase; the controller must not start a new frame until this block is idle.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- BAUD_DIV, CLK_HZ/BAUD (434 at defaults), clock cycles per UART bit. Must be >= 2.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- sample_data  in  12  ADC conversion result.
- sample_channel  in  3  ADC channel the sample came from.
- sample_valid  in  1  sample present this cycle.
- sample_ready  out  1  block can accept a sample.
- overrun  out  1  one-cycle pulse: sample_valid asserted while sample_ready is low; that sample is dropped.
- tx  out  1  UART serial output, idle high.
- busy  out  1  packet in progress (inverse of sample_ready).
- pkt_count  out  8  packets fully transmitted; wraps 255->0.

Behaviour:
- Reset values (reset high, asynchronous):
  - tx=1, sample_ready=1, busy=0, overrun=0, pkt_count=0.
  - Internal 4-bit seq=0; FSM in IDLE; baud and bit counters cleared.
- Handshake:
  - A sample is accepted on a clock edge where sample_valid & sample_ready.
  - sample_data and sample_channel are latched at that edge.
  - sample_ready drops the following cycle and stays low until the packet completes.
  - There is no queue. Valid while not ready raises overrun for exactly one cycle per offending cycle.
- Packet bytes, built at acceptance:
  - b0 = HEADER
  - b1 = {seq[3:0], 1'b0, channel[2:0]}
  - b2 = {4'b0000, data[11:8]}
  - b3 = data[7:0]
  - b4 = b1 ^ b2 ^ b3
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT, NEXT_BYTE.
  - IDLE: tx=1, sample_ready=1. On accept -> START_BIT with byte index 0.
  - START_BIT: tx=0 for BAUD_DIV cycles -> DATA_BITS.
  - DATA_BITS: 8 bits, LSB first, each held BAUD_DIV cycles -> STOP_BIT.
  - STOP_BIT: tx=1 for BAUD_DIV cycles -> NEXT_BYTE.
  - NEXT_BYTE: single cycle, tx=1. If byte index < 4: increment index -> START_BIT. Else: seq+=1 (wraps 15->0), pkt_count+=1 -> IDLE.
- Timing:
  - Start bit of b0 appears on tx the cycle after acceptance.
  - Each byte occupies 10*BAUD_DIV cycles, plus 1 NEXT_BYTE cycle between bytes.
  - Total busy time = 50*BAUD_DIV + 5 cycles; sample_ready returns high on the cycle after the final NEXT_BYTE.
- tx is a registered output (glitch-free).
- Baud counter counts 0..BAUD_DIV-1 and restarts at every state entry, so there is no drift across bytes.
- Reset mid-packet: tx forced high immediately and the packet is abandoned. seq and pkt_count clear; no partial byte resumes after reset release.
- Simultaneous: sample_valid arriving in the same cycle as the final NEXT_BYTE is not accepted (ready still low) and pulses overrun.

Decomposition:
- Shared package (pixel_test_pkg): FSM state encoding localparams, HEADER value, packet length (5), and the channel/data widths shared with the ADC driver.
- One natural sub-module: uart_tx_byte. It takes an 8-bit byte plus a start strobe, generates the baud timing and 8N1 framing, and returns done.
- The top level then holds the packet assembler/sequencer, seq and pkt_count.

Test Plan (CLK_HZ=1000, BAUD=100, BAUD_DIV=10):
- Single sample: data=12'hABC, channel=3 after reset -> bytes A5, 03, 0A, BC, B5 decoded from tx; busy for 505 cycles; pkt_count=1.
- Sequence wrap: 17 back-to-back packets -> b1 upper nibble runs 0..F then 0; pkt_count=17.
- Overrun: valid pulsed 20 cycles into a packet -> overrun high exactly one cycle; transmitted packet unchanged; no extra packet sent.
- Bit timing: measure the start-bit falling edge to each data-bit boundary -> exactly 10 cycles per bit; tx high during NEXT_BYTE gaps.
- Mid-packet reset: assert reset during DATA_BITS of b2 -> tx=1 and sample_ready=1 within the same cycle. A new sample after release yields a clean packet with seq=0.
- Boundary data: data=12'h000, ch=0 gives A5 00 00 00 00; data=12'hFFF, ch=7 gives A5 07 0F FF F7 -> checksum matches both.
